exe_sequencer: RTL and testbench

- Program-driven controller for the `exe` ALU/register-file unit. It holds a small instruction store and steps through it, one instruction at a time.
- For each instruction it drives operands and opcode into `exe` and captures the combinational result and flags. It then writes the result back through exe's write port (`i_reg2`/`i_data2`).
- It sits between a host loader (program load, start/abort) and one `exe` instance. The sequencer is the only driver of the `exe` inputs.

---
 rtl/exe_sequencer.sv | 173 +++++++++++++++++
 tb/tb_exe_sequencer.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_sequencer.sv
// exe_sequencer: steps through a small instruction store and drives one
// `exe` ALU/register-file unit. Each instruction takes two cycles: EXEC
// presents operands and captures exe's combinational result, then WB
// presents the captured result on exe's write port.
//
// Host protocol: i_start is a level sampled on every clock. It is taken
// only in IDLE; a start sampled while busy is dropped, not queued.
// i_abort is sampled only while busy. It wins over halt and
// end-of-store, returns to IDLE on the next edge and never raises
// o_done. There is no ready/acknowledge: o_busy rising is the start
// acknowledge, and o_done is a one-cycle pulse in the first IDLE cycle
// after a program runs to completion.
module exe_sequencer #(
   parameter int DATA_W  = 10,
   parameter int RA_W    = 4,
   parameter int PC_W    = 4,
   parameter int INSTR_W = 28
) (
   input  logic               i_clk,
   input  logic               i_rsn,
   input  logic               i_prog_we,
   input  logic [PC_W-1:0]    i_prog_addr,
   input  logic [INSTR_W-1:0] i_prog_data,
   input  logic               i_start,
   input  logic [PC_W-1:0]    i_start_pc,
   input  logic               i_abort,
   input  logic [DATA_W-1:0]  i_exe_data,
   input  logic [3:0]         i_exe_flag,
   output logic [2:0]         o_oper,
   output logic [RA_W-1:0]    o_reg0,
   output logic [RA_W-1:0]    o_reg1,
   output logic [RA_W-1:0]    o_reg2,
   output logic [DATA_W-1:0]  o_data2,
   output logic [DATA_W-1:0]  o_data,
   output logic               o_imm,
   output logic [PC_W-1:0]    o_pc,
   output logic               o_busy,
   output logic               o_done,
   output logic [DATA_W-1:0]  o_result,
   output logic [3:0]         o_flag,
   output logic [1:0]         o_state
);

   // Instruction field positions.
   localparam int HALT_BIT = 27;
   localparam int IMM_BIT  = 26;
   localparam int OPER_LSB = 23;
   localparam int RD_LSB   = 19;
   localparam int RS0_LSB  = 15;
   localparam int RS1_LSB  = 11;
   localparam int RSVD_BIT = 10;
   localparam int DEPTH    = 2 ** PC_W;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_WB   = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [PC_W-1:0]      pc_q, pc_d;
   logic [DATA_W-1:0]    result_q;
   logic [3:0]           flag_q;
   logic                 done_q, done_d;
   logic                 capture;
   logic [INSTR_W-1:0]   store [DEPTH];
   logic [INSTR_W-1:0]   instr;
   logic                 last_instr;
   logic                 unused_rsvd;

   // Current instruction is read combinationally from the PC.
   assign instr       = store[pc_q];
   assign unused_rsvd = instr[RSVD_BIT];
   // Stop after this instruction: halt bit, or the last store word (no wrap).
   assign last_instr  = instr[HALT_BIT] || (pc_q == {PC_W{1'b1}});

   // Program store: host writes are accepted only while idle; no reset.
   always_ff @(posedge i_clk) begin
      if (i_prog_we && (state_q == S_IDLE)) begin
         store[i_prog_addr] <= i_prog_data;
      end
   end

   // State, PC, done pulse and captured result/flags.
   always_ff @(posedge i_clk or negedge i_rsn) begin
      if (!i_rsn) begin
         state_q  <= S_IDLE;
         pc_q     <= '0;
         done_q   <= 1'b0;
         result_q <= '0;
         flag_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         done_q  <= done_d;
         if (capture) begin
            result_q <= i_exe_data;
            flag_q   <= i_exe_flag;
         end
      end
   end

   // Next-state logic: start from IDLE, EXEC->WB, WB->EXEC or back to IDLE.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      done_d  = 1'b0;
      capture = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               pc_d    = i_start_pc;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (i_abort) begin
               state_d = S_IDLE;
            end else begin
               capture = 1'b1;
               state_d = S_WB;
            end
         end
         S_WB: begin
            if (i_abort) begin
               state_d = S_IDLE;
            end else if (last_instr) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else begin
               pc_d    = pc_q + 1'b1;
               state_d = S_EXEC;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // exe drive: zero in IDLE, operands in EXEC and WB, write port only in WB.
   always_comb begin
      o_oper  = '0;
      o_reg0  = '0;
      o_reg1  = '0;
      o_reg2  = '0;
      o_data2 = '0;
      o_data  = '0;
      o_imm   = 1'b0;
      if ((state_q == S_EXEC) || (state_q == S_WB)) begin
         o_oper = instr[OPER_LSB +: 3];
         o_reg0 = instr[RS0_LSB +: RA_W];
         o_reg1 = instr[RS1_LSB +: RA_W];
         o_imm  = instr[IMM_BIT];
         o_data = instr[DATA_W-1:0];
      end
      if (state_q == S_WB) begin
         o_data2 = result_q;
         // An abort in WB suppresses the write in the same cycle.
         if (!i_abort) begin
            o_reg2 = instr[RD_LSB +: RA_W];
         end
      end
   end

   assign o_pc     = pc_q;
   assign o_busy   = (state_q != S_IDLE);
   assign o_done   = done_q;
   assign o_result = result_q;
   assign o_flag   = flag_q;
   assign o_state  = state_q;

endmodule

// File: tb/tb_exe_sequencer.sv
// Bench for exe_sequencer: a behavioural exe unit (ALU + register file)
// is attached, and whole programs are predicted by a program-level
// interpreter that walks the store image.
module tb_exe_sequencer;

   logic        clk = 1'b0;
   logic        i_rsn;
   logic        i_prog_we;
   logic [3:0]  i_prog_addr;
   logic [27:0] i_prog_data;
   logic        i_start;
   logic [3:0]  i_start_pc;
   logic        i_abort;
   logic [9:0]  exe_data;
   logic [3:0]  exe_flag;
   logic [2:0]  o_oper;
   logic [3:0]  o_reg0, o_reg1, o_reg2;
   logic [9:0]  o_data2, o_data;
   logic        o_imm;
   logic [3:0]  o_pc;
   logic        o_busy, o_done;
   logic [9:0]  o_result;
   logic [3:0]  o_flag;
   logic [1:0]  dbg_state;

   int n_checks;
   int n_errors;

   // clock
   always #5 clk = ~clk;

   exe_sequencer dut (
      .i_clk(clk), .i_rsn(i_rsn), .i_prog_we(i_prog_we),
      .i_prog_addr(i_prog_addr), .i_prog_data(i_prog_data),
      .i_start(i_start), .i_start_pc(i_start_pc), .i_abort(i_abort),
      .i_exe_data(exe_data), .i_exe_flag(exe_flag),
      .o_oper(o_oper), .o_reg0(o_reg0), .o_reg1(o_reg1), .o_reg2(o_reg2),
      .o_data2(o_data2), .o_data(o_data), .o_imm(o_imm), .o_pc(o_pc),
      .o_busy(o_busy), .o_done(o_done), .o_result(o_result),
      .o_flag(o_flag), .o_state(dbg_state)
   );

   // ---------------- exe behavioural unit ----------------
   function automatic logic [9:0] alu(input logic [2:0] op, input logic [9:0] a, input logic [9:0] b);
      case (op)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return a & b;
         3'd3: return a | b;
         3'd4: return a ^ b;
         3'd5: return a;
         3'd6: return b;
         default: return {a[8:0], 1'b0};
      endcase
   endfunction

   function automatic logic [3:0] flg(input logic [9:0] a, input logic [9:0] b, input logic [9:0] r);
      return {r[9], (r == 10'd0), a[9] ^ b[9], ^r};
   endfunction

   logic [9:0] rf [16];
   logic [9:0] exe_a, exe_b;
   logic [3:0] wr_a;
   logic [9:0] wr_d;
   logic       rf_clr;

   always_comb begin
      exe_a    = rf[o_reg0];
      exe_b    = o_imm ? o_data : rf[o_reg1];
      exe_data = alu(o_oper, exe_a, exe_b);
      exe_flag = flg(exe_a, exe_b, exe_data);
   end

   always @(negedge clk) begin
      wr_a <= o_reg2;
      wr_d <= o_data2;
   end

   always @(posedge clk) begin
      if (rf_clr) begin
         for (int i = 0; i < 16; i++) rf[i] <= 10'd0;
      end else if (i_rsn && (wr_a != 4'd0)) begin
         rf[wr_a] <= wr_d;
      end
   end

   // ---------------- reference model and scoreboard ----------------
   logic [27:0] prog_img [16];
   logic [9:0]  ref_rf [16];
   logic [13:0] exp_q [$];
   logic [13:0] act_q [$];
   logic [9:0]  exp_result;
   logic [3:0]  exp_flag;
   logic [3:0]  exp_pc;
   logic [9:0]  res_t [64];
   logic [3:0]  pc_t [64];

   function automatic logic [27:0] mk(input logic h, input logic im, input logic [2:0] op,
                                      input logic [3:0] rd, input logic [3:0] rs0, input logic [3:0] rs1,
                                      input logic [9:0] iv, input logic rsv);
      return {h, im, op, rd, rs0, rs1, rsv, iv};
   endfunction

   // Interpret the program image from spc; n = instructions executed.
   task automatic ref_run(input logic [3:0] spc, output int n);
      logic [3:0]  pc;
      logic [27:0] w;
      logic [9:0]  a, b, r;
      pc = spc;
      n  = 0;
      exp_q.delete();
      for (int k = 0; k < 16; k++) begin
         w = prog_img[pc];
         a = ref_rf[w[18:15]];
         b = w[26] ? w[9:0] : ref_rf[w[14:11]];
         r = alu(w[25:23], a, b);
         exp_result = r;
         exp_flag   = flg(a, b, r);
         if (w[22:19] != 4'd0) begin
            exp_q.push_back({w[22:19], r});
            ref_rf[w[22:19]] = r;
         end
         n++;
         exp_pc = pc;
         if (w[27] || (pc == 4'd15)) break;
         pc = pc + 4'd1;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic clear_regs();
      @(posedge clk); #1 rf_clr = 1'b1;
      @(posedge clk); #1 rf_clr = 1'b0;
      for (int i = 0; i < 16; i++) ref_rf[i] = 10'd0;
   endtask

   task automatic load_word(input logic [3:0] a, input logic [27:0] d);
      @(posedge clk); #1;
      i_prog_we = 1'b1; i_prog_addr = a; i_prog_data = d;
      @(posedge clk); #1;
      i_prog_we = 1'b0;
      prog_img[a] = d;
   endtask

   // Returns one tick into the first EXEC cycle.
   task automatic start_prog(input logic [3:0] spc);
      @(posedge clk); #1;
      i_start = 1'b1; i_start_pc = spc;
      @(posedge clk); #1;
      i_start = 1'b0;
   endtask

   // Run until o_done (bounded); done_at is the 0-based cycle index of the pulse.
   task automatic run_collect(input logic [3:0] spc, input int budget, output int busy_n, output int done_at);
      start_prog(spc);
      busy_n  = 0;
      done_at = -1;
      act_q.delete();
      for (int c = 0; c < budget && c < 64; c++) begin
         @(negedge clk);
         res_t[c] = o_result;
         pc_t[c]  = o_pc;
         if (o_busy) busy_n++;
         if (o_reg2 != 4'd0) act_q.push_back({o_reg2, o_data2});
         if (o_done) begin
            done_at = c;
            break;
         end
      end
      if (done_at < 0) chk("done timeout", 32'd0, 32'd1);
   endtask

   task automatic cmp_writes(input string name);
      chk({name, " write count"}, act_q.size(), exp_q.size());
      for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
         chk({name, " write"}, act_q[i], exp_q[i]);
   endtask

   // ---------------- decode vector table ----------------
   typedef struct {
      logic [3:0] pc;   logic imm; logic [2:0] op; logic [3:0] rd; logic [3:0] rs0; logic [3:0] rs1;
      logic [9:0] immv; logic resv;
      logic [2:0] e_oper; logic [3:0] e_r0; logic [3:0] e_r1; logic [3:0] e_rd; logic e_imm; logic [9:0] e_data;
   } vec_t;

   vec_t tbl [4];

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int busy_n, done_at, n;
      logic [9:0]  er;
      logic [13:0] raw_exp [2];
      logic [3:0]  pc_exp [8];
      logic [3:0]  spc;

      n_checks = 0; n_errors = 0;
      i_rsn = 1'b0; i_prog_we = 1'b0; i_prog_addr = '0; i_prog_data = '0;
      i_start = 1'b0; i_start_pc = '0; i_abort = 1'b0; rf_clr = 1'b0;

      tbl[0] = '{4'd0,  1'b0, 3'd1, 4'd5,  4'd3,  4'd4,  10'd0,   1'b0, 3'd1, 4'd3,  4'd4,  4'd5,  1'b0, 10'd0};
      tbl[1] = '{4'd3,  1'b1, 3'd0, 4'd7,  4'd2,  4'd9,  10'h155, 1'b0, 3'd0, 4'd2,  4'd9,  4'd7,  1'b1, 10'h155};
      tbl[2] = '{4'd8,  1'b1, 3'd6, 4'd0,  4'd15, 4'd0,  10'h3FF, 1'b1, 3'd6, 4'd15, 4'd0,  4'd0,  1'b1, 10'h3FF};
      tbl[3] = '{4'd12, 1'b0, 3'd7, 4'd15, 4'd1,  4'd14, 10'h2AA, 1'b1, 3'd7, 4'd1,  4'd14, 4'd15, 1'b0, 10'h2AA};

      // reset state
      clear_regs();
      @(negedge clk);
      chk("rst busy", o_busy, 0);   chk("rst reg2", o_reg2, 0);
      chk("rst pc", o_pc, 0);       chk("rst result", o_result, 0);
      chk("rst flag", o_flag, 0);   chk("rst done", o_done, 0);
      chk("rst oper", o_oper, 0);   chk("rst data", o_data, 0);
      @(posedge clk); #1 i_rsn = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("idle hold busy", o_busy, 0);
      end

      // decode table: single halt instruction per entry
      for (int v = 0; v < 4; v++) begin
         clear_regs();
         load_word(tbl[v].pc, mk(1'b1, tbl[v].imm, tbl[v].op, tbl[v].rd, tbl[v].rs0, tbl[v].rs1,
                                 tbl[v].immv, tbl[v].resv));
         er = alu(tbl[v].e_oper, 10'd0, tbl[v].e_imm ? tbl[v].e_data : 10'd0);
         start_prog(tbl[v].pc);
         @(negedge clk);
         chk("exec oper", o_oper, tbl[v].e_oper);  chk("exec reg0", o_reg0, tbl[v].e_r0);
         chk("exec reg1", o_reg1, tbl[v].e_r1);    chk("exec imm", o_imm, tbl[v].e_imm);
         chk("exec data", o_data, tbl[v].e_data);  chk("exec reg2", o_reg2, 0);
         chk("exec busy", o_busy, 1);              chk("exec pc", o_pc, tbl[v].pc);
         @(negedge clk);
         chk("wb reg2", o_reg2, tbl[v].e_rd);      chk("wb data2", o_data2, er);
         chk("wb result", o_result, er);           chk("wb oper", o_oper, tbl[v].e_oper);
         @(negedge clk);
         chk("end done", o_done, 1);  chk("end busy", o_busy, 0);
         chk("end reg2", o_reg2, 0);  chk("end pc", o_pc, tbl[v].pc);
         @(negedge clk);
         chk("done one cycle", o_done, 0);
      end

      // immediate load + read-after-write
      clear_regs();
      load_word(4'd0, mk(1'b0, 1'b1, 3'd0, 4'd1, 4'd0, 4'd0, 10'd27, 1'b0));
      load_word(4'd1, mk(1'b1, 1'b0, 3'd0, 4'd2, 4'd1, 4'd1, 10'd0, 1'b0));
      run_collect(4'd0, 20, busy_n, done_at);
      chk("raw done cycle", done_at, 4);
      chk("raw busy cycles", busy_n, 4);
      chk("raw result 1", res_t[1], 27);
      chk("raw result 2", res_t[3], 54);
      raw_exp[0] = {4'd1, 10'd27};
      raw_exp[1] = {4'd2, 10'd54};
      chk("raw write count", act_q.size(), 2);
      for (int i = 0; i < act_q.size() && i < 2; i++) chk("raw write", act_q[i], raw_exp[i]);

      // end of store: runs 14 and 15, no wrap
      clear_regs();
      load_word(4'd14, mk(1'b0, 1'b1, 3'd0, 4'd3, 4'd0, 4'd0, 10'd5, 1'b0));
      load_word(4'd15, mk(1'b0, 1'b1, 3'd0, 4'd4, 4'd3, 4'd0, 10'd1, 1'b0));
      run_collect(4'd14, 20, busy_n, done_at);
      chk("eos done cycle", done_at, 4);
      chk("eos busy cycles", busy_n, 4);
      chk("eos pc first", pc_t[0], 14);
      chk("eos pc second", pc_t[2], 15);
      chk("eos result", o_result, 6);
      raw_exp[0] = {4'd3, 10'd5};
      raw_exp[1] = {4'd4, 10'd6};
      chk("eos write count", act_q.size(), 2);
      for (int i = 0; i < act_q.size() && i < 2; i++) chk("eos write", act_q[i], raw_exp[i]);
      repeat (3) begin
         @(negedge clk);
         chk("eos pc hold", o_pc, 15);
         chk("eos idle", o_busy, 0);
      end

      // abort in WB of the first instruction
      clear_regs();
      load_word(4'd0, mk(1'b0, 1'b1, 3'd0, 4'd3, 4'd0, 4'd0, 10'd9, 1'b0));
      load_word(4'd1, mk(1'b1, 1'b1, 3'd0, 4'd6, 4'd0, 4'd0, 10'd100, 1'b0));
      start_prog(4'd0);
      @(posedge clk); #1 i_abort = 1'b1;
      #1;
      chk("abort wb reg2", o_reg2, 0);
      chk("abort wb busy", o_busy, 1);
      chk("abort wb result", o_result, 9);
      @(posedge clk); #1 i_abort = 1'b0;
      @(negedge clk);
      chk("abort idle", o_busy, 0);
      chk("abort no done", o_done, 0);
      @(negedge clk);
      chk("abort no done later", o_done, 0);
      chk("abort no write", rf[3], 0);
      chk("abort result hold", o_result, 9);

      // abort in EXEC: no capture
      start_prog(4'd1);
      i_abort = 1'b1;
      @(posedge clk); #1 i_abort = 1'b0;
      @(negedge clk);
      chk("abort exec idle", o_busy, 0);
      chk("abort exec no capture", o_result, 9);
      chk("abort exec no done", o_done, 0);
      @(negedge clk);
      chk("abort exec no write", rf[6], 0);

      // program write while busy is ignored
      clear_regs();
      load_word(4'd5, mk(1'b1, 1'b1, 3'd0, 4'd7, 4'd0, 4'd0, 10'd33, 1'b0));
      start_prog(4'd5);
      i_prog_we = 1'b1; i_prog_addr = 4'd5;
      i_prog_data = mk(1'b1, 1'b1, 3'd0, 4'd7, 4'd0, 4'd0, 10'd44, 1'b0);
      @(posedge clk); #1 i_prog_we = 1'b0;
      repeat (2) @(negedge clk);
      run_collect(4'd5, 10, busy_n, done_at);
      chk("busy write ignored", o_result, 33);
      chk("busy write count", act_q.size(), 1);
      if (act_q.size() > 0) chk("busy write readback", act_q[0], {4'd7, 10'd33});

      // start ignored while busy: 4-instruction program
      clear_regs();
      load_word(4'd0, mk(1'b0, 1'b1, 3'd0, 4'd1, 4'd0, 4'd0, 10'd3, 1'b0));
      load_word(4'd1, mk(1'b0, 1'b1, 3'd0, 4'd2, 4'd1, 4'd0, 10'd4, 1'b0));
      load_word(4'd2, mk(1'b0, 1'b0, 3'd0, 4'd3, 4'd1, 4'd2, 10'd0, 1'b0));
      load_word(4'd3, mk(1'b1, 1'b0, 3'd1, 4'd4, 4'd3, 4'd1, 10'd0, 1'b0));
      pc_exp = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3};
      start_prog(4'd0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("start ignored pc", o_pc, pc_exp[i]);
         if (i == 2) begin
            @(posedge clk); #1 i_start = 1'b1; i_start_pc = 4'd9;
         end
         if (i == 3) begin
            @(posedge clk); #1 i_start = 1'b0;
         end
      end
      @(negedge clk);
      chk("start ignored done", o_done, 1);
      chk("start ignored pc end", o_pc, 3);
      chk("start ignored result", o_result, 7);

      // reset in the WB cycle of the second instruction
      clear_regs();
      start_prog(4'd0);
      repeat (4) @(negedge clk);
      chk("mid-run wb reg2", o_reg2, 2);
      #2 i_rsn = 1'b0;
      #1;
      chk("mid-run reset reg2", o_reg2, 0);
      chk("mid-run reset busy", o_busy, 0);
      chk("mid-run reset pc", o_pc, 0);
      chk("mid-run reset result", o_result, 0);
      @(posedge clk); #1;
      chk("mid-run no write", rf[2], 0);
      chk("mid-run earlier write", rf[1], 3);
      i_rsn = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("post-reset idle", o_busy, 0);
      end

      // randomized programs against the interpreter
      for (int it = 0; it < 20; it++) begin
         clear_regs();
         for (int a = 0; a < 16; a++) begin
            load_word(4'(a), mk(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                                3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                                10'($urandom_range(0, 1023)), 1'($urandom_range(0, 1))));
         end
         spc = 4'($urandom_range(0, 15));
         ref_run(spc, n);
         run_collect(spc, 50, busy_n, done_at);
         chk("rand done cycle", done_at, 2 * n);
         chk("rand busy cycles", busy_n, 2 * n);
         cmp_writes("rand");
         chk("rand result", o_result, exp_result);
         chk("rand flag", o_flag, exp_flag);
         chk("rand pc", o_pc, exp_pc);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
